// File: rtl/gray_tracker.sv
// gray_tracker: watches a reflected-binary gray code and tracks legal +/-1
// steps, the direction of the last move and a signed net step count. Any
// multi-step jump is flagged, and the tracker relocks on the next sample.
//
// Optional feature macro: GRAY_TRACKER_ERRCNT_EN enables the saturating
// illegal-transition counter on err_cnt. Without it, err_cnt is tied to 0.
//
// Ports:
//   clk      - single clock; all state updates on the rising edge
//   reset    - synchronous, active-high reset
//   g        - gray code under observation (WIDTH bits)
//   g_valid  - marks g as a sample to evaluate this cycle
//   bin      - binary decode of the last accepted sample
//   dir      - direction of the last legal move (1 = up, 0 = down)
//   moved    - one-cycle pulse on each legal +1/-1 step
//   err      - one-cycle pulse on each illegal transition
//   locked   - high while tracking (LOCKED state)
//   pos      - signed net step count since lock (POS_W bits, wraps)
//   err_cnt  - saturating illegal-transition count (0 when feature is off)
module gray_tracker #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned POS_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] g,
  input  logic             g_valid,
  output logic [WIDTH-1:0] bin,
  output logic             dir,
  output logic             moved,
  output logic             err,
  output logic             locked,
  output logic [POS_W-1:0] pos,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] STEP_UP = WIDTH'(1);
  localparam logic [WIDTH-1:0] STEP_DN = {WIDTH{1'b1}};

  state_t           state, state_n;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] delta;
  logic [WIDTH-1:0] bin_n;
  logic             dir_n;
  logic             moved_n;
  logic             err_n;
  logic [POS_W-1:0] pos_n;

  // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    dec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dec[i] = ^(g >> i);
    end
  end

  // bin doubles as the previous-sample register: it only changes when prev does.
  assign delta = dec - bin;

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    bin_n   = bin;
    dir_n   = dir;
    pos_n   = pos;
    moved_n = 1'b0;
    err_n   = 1'b0;
    if (g_valid) begin
      unique case (state)
        UNLOCKED: begin
          bin_n   = dec;
          pos_n   = '0;
          state_n = LOCKED;
        end
        LOCKED: begin
          if (delta == STEP_UP) begin
            bin_n   = dec;
            dir_n   = 1'b1;
            pos_n   = pos + POS_W'(1);
            moved_n = 1'b1;
          end else if (delta == STEP_DN) begin
            bin_n   = dec;
            dir_n   = 1'b0;
            pos_n   = pos - POS_W'(1);
            moved_n = 1'b1;
          end else if (delta != '0) begin
            err_n   = 1'b1;
            state_n = FAULT;
          end
        end
        FAULT: begin
          // Relock keeps the accumulated position.
          bin_n   = dec;
          state_n = LOCKED;
        end
        default: state_n = UNLOCKED;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= UNLOCKED;
      bin    <= '0;
      dir    <= 1'b1;
      moved  <= 1'b0;
      err    <= 1'b0;
      locked <= 1'b0;
      pos    <= '0;
    end else begin
      state  <= state_n;
      bin    <= bin_n;
      dir    <= dir_n;
      moved  <= moved_n;
      err    <= err_n;
      locked <= (state_n == LOCKED);
      pos    <= pos_n;
    end
  end

`ifdef GRAY_TRACKER_ERRCNT_EN
  // Saturating count of illegal transitions.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= 8'd0;
    end else if (err_n && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: doc/gray_tracker.md
GRAY_TRACKER -- requirements
Module: gray_tracker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the gray code width in bits (legal range 2..8).
REQ-002 The block SHALL have parameter POS_W, default 8, giving the signed position counter width in bits.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port g  input  WIDTH  the reflected-binary gray code under observation, e.g. a gray counter's q output.
REQ-006 The block SHALL have port g_valid  input  1  high marks g as a sample to evaluate this cycle.
REQ-007 The block SHALL have port bin  output  WIDTH  binary decode of the last accepted sample.
REQ-008 The block SHALL have port dir  output  1  direction of the last legal move: 1 = up, 0 = down.
REQ-009 The block SHALL have port moved  output  1  one-cycle pulse on each legal +1/-1 step.
REQ-010 The block SHALL have port err  output  1  one-cycle pulse on each illegal transition.
REQ-011 The block SHALL have port locked  output  1  high while the state is LOCKED.
REQ-012 The block SHALL have port pos  output  POS_W  signed net step count since lock.
REQ-013 The block SHALL have port err_cnt  output  8  saturating illegal-transition count (see Configuration).

Function
REQ-014 The block SHALL decode as bin[WIDTH-1] = g[WIDTH-1] and bin[i] = bin[i+1] XOR g[i].
REQ-015 The block SHALL have FSM states UNLOCKED, LOCKED and FAULT.
REQ-016 In UNLOCKED, a g_valid sample SHALL load bin and the previous-value register, clear pos to 0 and enter LOCKED, with no moved or err pulse.
REQ-017 In LOCKED, each g_valid sample SHALL compute d = decode(g) - prev modulo 2^WIDTH.
REQ-018 If d = 0, the block SHALL leave bin, dir and pos unchanged and SHALL NOT pulse moved or err.
REQ-019 If d = +1, the block SHALL set dir = 1, increment pos, pulse moved and update bin and prev.
REQ-020 If d = -1 (all ones), the block SHALL set dir = 0, decrement pos, pulse moved and update bin and prev.
REQ-021 For any other d, the block SHALL pulse err, leave bin, dir and pos unchanged, and enter FAULT.
REQ-022 In FAULT, the next g_valid sample SHALL relock exactly as REQ-016 does, except that pos is held rather than cleared.
REQ-023 Wrap-around SHALL be legal: code for 2^WIDTH-1 to code for 0 is +1, and the reverse is -1.
REQ-024 pos SHALL wrap in two's complement; it SHALL NOT saturate.
REQ-025 All outputs SHALL be registered, appearing exactly one cycle after the g_valid sample that causes them.
REQ-026 moved and err SHALL be low in every cycle without a qualifying sample, and SHALL never be high together.
REQ-027 When g_valid is low, the block SHALL leave all state unchanged.

Reset
REQ-028 On reset, the block SHALL set state UNLOCKED, bin = 0, dir = 1, moved = 0, err = 0, locked = 0, pos = 0, err_cnt = 0.
REQ-029 If reset and g_valid are high in the same cycle, reset SHALL win and the sample SHALL be discarded.
REQ-030 Reset asserted mid-operation SHALL take effect on the next rising edge, regardless of state.

Configuration
REQ-031 With macro GRAY_TRACKER_ERRCNT_EN defined, err_cnt SHALL increment on each err pulse and saturate at 255.
REQ-032 Without GRAY_TRACKER_ERRCNT_EN, err_cnt SHALL be tied to 0 and the counter logic SHALL be omitted; all other behaviour SHALL be identical.

Verification
REQ-033 The bench SHALL drive reset for 3 cycles, then WIDTH=3 with g_valid=1 and g = 000,001,011,010,110,111,101,100,000; it SHALL check locked=1 after the first sample, eight moved pulses, dir=1 and pos=8.
REQ-034 The bench SHALL drive the same codes in reverse from lock at 000 (000,100,101,...,001,000); it SHALL check dir=0 and pos=-8 (0xF8).
REQ-035 The bench SHALL lock at 000, then apply 011 (binary 2); it SHALL check err=1 for one cycle, bin=000, locked=0 and err_cnt=1 (macro on) or 0 (macro off); it SHALL then apply 010 and check relock with bin=011 and pos unchanged.
REQ-036 The bench SHALL hold g=110 for 5 samples while locked, and SHALL check that there are no moved or err pulses and that pos is steady.
REQ-037 The bench SHALL assert reset together with g_valid and g=001 while pos=3, and SHALL check that the next cycle shows all reset values and locked=0.
REQ-038 The bench SHALL toggle g_valid low for 4 cycles while g changes by 2 codes, and SHALL check that no state change occurs during those cycles.
